mem_array: RTL

MEM_ARRAY -- requirements
Module: mem_array

---
 rtl/mem_array.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_array.sv
// rtl/mem_array.sv - per-channel temporal memory: captures first spike tick of each gamma cycle, replays it next cycle
// Optional feature macro MEM_PERSIST_EN: channels without a new capture keep replaying their previous time.
module mem_array #(
  parameter int N_CH              = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 4,
  parameter int DELAY             = 0
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            grst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] ovf
);

  localparam int TW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
  localparam int CW = $clog2(PULSE_WIDTH + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE, S_DONE} state_e;

  logic [TW-1:0]            tick_q, tick_d;
  logic [N_CH-1:0]          in_q, in_d;
  logic [N_CH-1:0]          rise;
  logic [N_CH-1:0]          cap_valid_q, cap_valid_d;
  logic [N_CH-1:0][TW-1:0]  cap_time_q, cap_time_d;
  logic [N_CH-1:0]          play_valid_q, play_valid_d;
  logic [N_CH-1:0][TW-1:0]  play_time_q, play_time_d;
  logic [N_CH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]          out_q, out_d;
  logic [N_CH-1:0]          ovf_q, ovf_d;
  state_e                   state_q [N_CH];
  state_e                   state_d [N_CH];

  always_comb begin
    logic [31:0] tgt;
    tgt          = '0;
    tick_d       = grst ? '0 : ((tick_q == TICK_MAX) ? tick_q : tick_q + 1'b1);
    in_d         = in;
    rise         = in & ~in_q;
    cap_valid_d  = cap_valid_q;
    cap_time_d   = cap_time_q;
    play_valid_d = play_valid_q;
    play_time_d  = play_time_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    state_d      = state_q;
    out_d        = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grst) begin
`ifdef MEM_PERSIST_EN
        if (cap_valid_q[i]) begin
          play_valid_d[i] = 1'b1;
          play_time_d[i]  = cap_time_q[i];
        end
`else
        play_valid_d[i] = cap_valid_q[i];
        play_time_d[i]  = cap_time_q[i];
`endif
        // a spike on the grst edge opens the new cycle's capture at time 0
        cap_valid_d[i] = rise[i];
        cap_time_d[i]  = '0;
        cnt_d[i]       = CW'(PULSE_WIDTH - 1);
        tgt            = 32'(play_time_d[i]) + 32'(DELAY);
        if (!play_valid_d[i]) begin
          state_d[i] = S_IDLE;
        end else if (tgt > 32'(GAMMA_CYCLE_WIDTH - 1)) begin
          state_d[i] = S_DONE;
          ovf_d[i]   = 1'b1;
        end else if (tgt == '0) begin
          state_d[i] = S_PULSE;
        end else begin
          state_d[i] = S_WAIT;
        end
      end else begin
        if (rise[i] && !cap_valid_q[i]) begin
          cap_valid_d[i] = 1'b1;
          cap_time_d[i]  = tick_d;
        end
        tgt = 32'(play_time_q[i]) + 32'(DELAY);
        case (state_q[i])
          S_WAIT: begin
            if (32'(tick_d) == tgt) begin
              state_d[i] = S_PULSE;
              cnt_d[i]   = CW'(PULSE_WIDTH - 1);
            end
          end
          S_PULSE: begin
            if (cnt_q[i] == '0) state_d[i] = S_DONE;
            else                cnt_d[i]   = cnt_q[i] - 1'b1;
          end
          default: ;
        endcase
      end
      out_d[i] = (state_d[i] == S_PULSE);
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      tick_q       <= '0;
      in_q         <= '0;
      cap_valid_q  <= '0;
      cap_time_q   <= '0;
      play_valid_q <= '0;
      play_time_q  <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      ovf_q        <= '0;
      for (int i = 0; i < N_CH; i++) state_q[i] <= S_IDLE;
    end else begin
      tick_q       <= tick_d;
      in_q         <= in_d;
      cap_valid_q  <= cap_valid_d;
      cap_time_q   <= cap_time_d;
      play_valid_q <= play_valid_d;
      play_time_q  <= play_time_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule
